vliw_bundle_packer: RTL and testbench

//  Producer side of the 4-slot VLIW bundle interface. Accepts a stream of scalar 32-bit

---
 rtl/vliw_bundle_packer.sv | 138 +++++++++++++
 tb/tb_vliw_bundle_packer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vliw_bundle_packer.sv
// Packs an in-order stream of 32-bit scalar instructions into 4-slot, 128-bit VLIW bundles.
// Optional VLIW_PACK_STATS_EN adds bundle/slot statistics counters and ports.
module vliw_bundle_packer #(
  parameter int TIMEOUT = 8,
  parameter int TIMER_W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_bundle
`ifdef VLIW_PACK_STATS_EN
  ,
  output logic [15:0]  stat_bundles,
  output logic [15:0]  stat_slots
`endif
);

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

  logic [31:0]        r_cur [4];
  logic [2:0]         r_cnt;
  logic [TIMER_W-1:0] r_timer;
  logic               r_out_valid;
  logic [127:0]       r_out_bundle;

  logic [2:0]   w_op;
  logic         w_legal;
  logic         w_rd1;
  logic         w_rd2;
  logic         w_conflict;
  logic         w_hazard;
  logic         w_timed_out;
  logic         w_out_free;
  logic         w_close;
  logic         w_accept;
  logic         w_store;
  logic [127:0] w_closed_bundle;

  assign w_op    = in_instr[2:0];
  assign w_legal = in_instr[31] &&
                   (w_op == 3'b000 || w_op == 3'b001 || w_op == 3'b010 || w_op == 3'b100);
  assign w_rd1   = (w_op == 3'b000 || w_op == 3'b001 || w_op == 3'b010);
  assign w_rd2   = (w_op == 3'b000 || w_op == 3'b001);

  // RAW/WAW against every filled slot of the bundle being built.
  always_comb begin
    w_conflict = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < r_cnt) begin
        if ((w_rd1 && in_instr[8:6] == r_cur[k][5:3]) ||
            (w_rd2 && in_instr[11:9] == r_cur[k][5:3]) ||
            (in_instr[5:3] == r_cur[k][5:3]))
          w_conflict = 1'b1;
      end
    end
  end

  always_comb begin
    w_closed_bundle = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < r_cnt) w_closed_bundle[32*k +: 32] = r_cur[k];
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready on that side;
  // out_bundle is held stable while out_valid && !out_ready.
  assign w_hazard    = in_valid && (r_cnt != 3'd0) && w_legal && w_conflict;
  assign w_timed_out = (TIMEOUT != 0) && (r_timer == TIMER_MAX);
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_close     = (r_cnt != 3'd0) && w_out_free &&
                       (w_hazard || r_cnt == 3'd4 || flush || w_timed_out);
  assign in_ready    = !flush && (r_cnt != 3'd4) && (!w_hazard || w_out_free);
  assign w_accept    = in_valid && in_ready;
  assign w_store     = w_accept && w_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) r_cur[k] <= '0;
      r_cnt <= 3'd0;
    end else if (w_close) begin
      if (w_store) r_cur[0] <= in_instr;
      r_cnt <= w_store ? 3'd1 : 3'd0;
    end else if (w_store) begin
      r_cur[r_cnt[1:0]] <= in_instr;
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // Dropped words still count as activity, so clear on any accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
    end else if (w_accept || w_close || r_cnt == 3'd0) begin
      r_timer <= '0;
    end else if (r_timer != TIMER_MAX) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_bundle <= '0;
    end else if (w_close) begin
      r_out_valid  <= 1'b1;
      r_out_bundle <= w_closed_bundle;
    end else if (r_out_valid && out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_bundle = r_out_bundle;

`ifdef VLIW_PACK_STATS_EN
  logic [15:0] r_stat_bundles;
  logic [15:0] r_stat_slots;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_bundles <= '0;
      r_stat_slots   <= '0;
    end else if (w_close) begin
      r_stat_bundles <= r_stat_bundles + 16'd1;
      r_stat_slots   <= r_stat_slots + {13'd0, r_cnt};
    end
  end

  assign stat_bundles = r_stat_bundles;
  assign stat_slots   = r_stat_slots;
`endif

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Directed bench for vliw_bundle_packer: packing, RAW/WAW closes, backpressure,
// idle timeout, flush, dropped words and asynchronous reset.
module tb_vliw_bundle_packer;

  localparam logic [31:0] MOV_R1_5  = 32'h8000_500C;
  localparam logic [31:0] MOV_R2_7  = 32'h8000_7014;
  localparam logic [31:0] ADDI_R3   = 32'h8000_101A;
  localparam logic [31:0] MOV_R4_9  = 32'h8000_9024;
  localparam logic [31:0] ADD_R2_R1 = 32'h8000_0250;
  localparam logic [31:0] MOV_R1_6  = 32'h8000_600C;
  localparam logic [31:0] ADD_R3_R2 = 32'h8000_0498;
  localparam logic [31:0] MOV_R5_3  = 32'h8000_302C;
  localparam logic [31:0] DROP_NV   = 32'h0000_500C;
  localparam logic [31:0] DROP_OP   = 32'h8000_000B;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_bundle;
`ifdef VLIW_PACK_STATS_EN
  logic [15:0]  stat_bundles;
  logic [15:0]  stat_slots;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] exp_q[$];

  vliw_bundle_packer #(.TIMEOUT(8), .TIMER_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bundle (out_bundle)
`ifdef VLIW_PACK_STATS_EN
    ,
    .stat_bundles (stat_bundles),
    .stat_slots   (stat_slots)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic f);
    in_valid = v;
    in_instr = instr;
    flush    = f;
    #1;
  endtask

  task automatic check_bundle(input string tag);
    logic [127:0] exp;
    exp = exp_q.pop_front();
    check_eq({tag, "_valid"}, {127'd0, out_valid}, 128'd1);
    check_eq({tag, "_data"}, out_bundle, exp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    check_eq("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check_eq("rst_out_bundle", out_bundle, 128'd0);
    #2 rst = 1'b0;
    cyc();
    check_eq("rst_in_ready", {127'd0, in_ready}, 128'd1);

    // four independent ops fill one bundle
    drive(1'b1, MOV_R1_5, 1'b0); cyc();
    drive(1'b1, MOV_R2_7, 1'b0); cyc();
    drive(1'b1, ADDI_R3,  1'b0); cyc();
    drive(1'b1, MOV_R4_9, 1'b0); cyc();
    drive(1'b0, '0, 1'b0);
    check_eq("full_in_ready", {127'd0, in_ready}, 128'd0);
    exp_q.push_back({MOV_R4_9, ADDI_R3, MOV_R2_7, MOV_R1_5});
    cyc();
    check_bundle("full");
    cyc();
    check_eq("full_one_cycle", {127'd0, out_valid}, 128'd0);

    // RAW closes the bundle, the reader starts the next one
    drive(1'b1, MOV_R1_5, 1'b0); cyc();
    drive(1'b1, ADD_R2_R1, 1'b0);
    check_eq("raw_in_ready", {127'd0, in_ready}, 128'd1);
    exp_q.push_back({96'h0, MOV_R1_5});
    cyc();
    check_bundle("raw_first");
    drive(1'b0, '0, 1'b1);
    exp_q.push_back({96'h0, ADD_R2_R1});
    cyc();
    check_bundle("raw_second");
    drive(1'b0, '0, 1'b0); cyc();

    // WAW gives two single-slot bundles
    drive(1'b1, MOV_R1_5, 1'b0); cyc();
    drive(1'b1, MOV_R1_6, 1'b0);
    exp_q.push_back({96'h0, MOV_R1_5});
    cyc();
    check_bundle("waw_first");
    drive(1'b0, '0, 1'b1);
    exp_q.push_back({96'h0, MOV_R1_6});
    cyc();
    check_bundle("waw_second");
    drive(1'b0, '0, 1'b0); cyc();

    // backpressure with a pending bundle and a hazard
    out_ready = 1'b0;
    drive(1'b1, MOV_R1_5, 1'b0); cyc();
    drive(1'b0, '0, 1'b1); cyc();
    drive(1'b1, MOV_R2_7, 1'b0);
    check_eq("bp_accept_ready", {127'd0, in_ready}, 128'd1);
    cyc();
    drive(1'b1, ADD_R3_R2, 1'b0);
    check_eq("bp_hazard_stall", {127'd0, in_ready}, 128'd0);
    cyc();
    check_eq("bp_stable", out_bundle, {96'h0, MOV_R1_5});
    check_eq("bp_still_stall", {127'd0, in_ready}, 128'd0);
    cyc();
    check_eq("bp_stable2", out_bundle, {96'h0, MOV_R1_5});
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", {127'd0, in_ready}, 128'd1);
    exp_q.push_back({96'h0, MOV_R2_7});
    cyc();
    check_bundle("bp_close");
    drive(1'b0, '0, 1'b1);
    exp_q.push_back({96'h0, ADD_R3_R2});
    cyc();
    check_bundle("bp_held_input");
    drive(1'b0, '0, 1'b0); cyc();

    // idle timeout: accept edge, 8 idle increments, close, then out_valid
    drive(1'b1, MOV_R1_5, 1'b0); cyc();
    drive(1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) cyc();
    check_eq("timeout_not_early", {127'd0, out_valid}, 128'd0);
    exp_q.push_back({96'h0, MOV_R1_5});
    cyc();
    check_bundle("timeout");
    cyc();

    // dropped words use no slot; flush closes a 2-slot bundle
    drive(1'b1, MOV_R1_5, 1'b0); cyc();
    drive(1'b1, DROP_NV,  1'b0); cyc();
    drive(1'b1, DROP_OP,  1'b0); cyc();
    drive(1'b1, MOV_R2_7, 1'b0); cyc();
    drive(1'b0, '0, 1'b1);
    exp_q.push_back({64'h0, MOV_R2_7, MOV_R1_5});
    cyc();
    check_bundle("flush_two");
    drive(1'b0, '0, 1'b0); cyc();
    check_eq("flush_empty_idle", {127'd0, out_valid}, 128'd0);

    // asynchronous reset with cnt==3 and a pending bundle
    out_ready = 1'b0;
    drive(1'b1, MOV_R1_5, 1'b0); cyc();
    drive(1'b0, '0, 1'b1); cyc();
    drive(1'b1, MOV_R2_7, 1'b0); cyc();
    drive(1'b1, ADDI_R3,  1'b0); cyc();
    drive(1'b1, MOV_R4_9, 1'b0); cyc();
    drive(1'b0, '0, 1'b0);
    check_eq("pre_rst_valid", {127'd0, out_valid}, 128'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", {127'd0, out_valid}, 128'd0);
    check_eq("async_rst_bundle", out_bundle, 128'd0);
    cyc();
    #2 rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, MOV_R5_3, 1'b0);
    check_eq("post_rst_ready", {127'd0, in_ready}, 128'd1);
    cyc();
    drive(1'b0, '0, 1'b1);
    exp_q.push_back({96'h0, MOV_R5_3});
    cyc();
    check_bundle("post_rst");
    drive(1'b0, '0, 1'b0); cyc();
    check_eq("post_rst_drain", {127'd0, out_valid}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
